lru_replacement_ctrl: RTL and testbench

- Set-level replacement controller on the controller side of the per-way age/eviction interface: drives `accessed`, `accessedWayAge` and `allocate`; reads each way's `valid`, `dirty`, `myAge` and `expired`.
- Per lookup it updates way ages on a hit. On a miss it picks a victim, runs a dirty writeback handshake if needed, then allocates the victim.
- Sits between the cache request pipeline and the NUM_WAYS way instances of one set.

---
 rtl/cache_repl_pkg.sv | 24 ++
 rtl/lru_replacement_ctrl_if.sv | 43 ++++
 rtl/lru_victim_select.sv | 56 +++++
 rtl/lru_replacement_ctrl.sv | 172 +++++++++++++++++
 tb/tb_lru_replacement_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_repl_pkg.sv
// rtl/cache_repl_pkg.sv - shared types and helpers for the set replacement controller
package cache_repl_pkg;

    localparam int AGE_WIDTH = 8;

    typedef logic [AGE_WIDTH-1:0] age_t;

    localparam age_t AGE_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_HIT,
        S_WRITEBACK,
        S_ALLOC,
        S_RESP
    } state_t;

    // Isolates the lowest set bit; callers truncate to their way count.
    function automatic logic [31:0] lowest_one(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

endpackage

// File: rtl/lru_replacement_ctrl_if.sv
// rtl/lru_replacement_ctrl_if.sv - request/way/writeback bundle; multiHitErr exists only with LRU_MULTI_HIT_CHECK_EN
interface lru_replacement_ctrl_if #(
    parameter int NUM_WAYS      = 4,
    parameter int COUNTER_WIDTH = 8
);
    logic                              reqValid;
    logic                              reqReady;
    logic [NUM_WAYS-1:0]               wayHit;
    logic [NUM_WAYS-1:0]               wayValid;
    logic [NUM_WAYS-1:0]               wayDirty;
    logic [NUM_WAYS-1:0]               wayExpired;
    logic [NUM_WAYS*COUNTER_WIDTH-1:0] wayAge;
    logic                              accessed;
    logic [COUNTER_WIDTH-1:0]          accessedWayAge;
    logic [NUM_WAYS-1:0]               allocate;
    logic [NUM_WAYS-1:0]               victimWay;
    logic                              wbReq;
    logic                              wbAck;
    logic                              respValid;
    logic                              respHit;
`ifdef LRU_MULTI_HIT_CHECK_EN
    logic                              multiHitErr;
`endif

    modport master (
        input  reqValid, wayHit, wayValid, wayDirty, wayExpired, wayAge, wbAck,
        output reqReady, accessed, accessedWayAge, allocate, victimWay, wbReq,
               respValid, respHit
`ifdef LRU_MULTI_HIT_CHECK_EN
        , output multiHitErr
`endif
    );

    modport slave (
        output reqValid, wayHit, wayValid, wayDirty, wayExpired, wayAge, wbAck,
        input  reqReady, accessed, accessedWayAge, allocate, victimWay, wbReq,
               respValid, respHit
`ifdef LRU_MULTI_HIT_CHECK_EN
        , input multiHitErr
`endif
    );

endinterface

// File: rtl/lru_victim_select.sv
// rtl/lru_victim_select.sv - combinational victim picker: invalid, then expired, then oldest way
module lru_victim_select
    import cache_repl_pkg::*;
#(
    parameter int NUM_WAYS      = 4,
    parameter int COUNTER_WIDTH = 8
) (
    input  logic [NUM_WAYS-1:0]               way_valid,
    input  logic [NUM_WAYS-1:0]               way_expired,
    input  logic [NUM_WAYS*COUNTER_WIDTH-1:0] way_age,
    output logic [NUM_WAYS-1:0]               victim,
    output logic [COUNTER_WIDTH-1:0]          victim_age
);

    logic [NUM_WAYS-1:0]      invalid_oh;
    logic [NUM_WAYS-1:0]      expired_oh;
    logic [NUM_WAYS-1:0]      oldest_oh;
    logic [COUNTER_WIDTH-1:0] oldest_age;

    assign invalid_oh = NUM_WAYS'(lowest_one(32'(~way_valid)));
    assign expired_oh = NUM_WAYS'(lowest_one(32'(way_expired)));

    // Strict greater-than keeps the lowest index on equal ages.
    always_comb begin
        oldest_oh    = '0;
        oldest_oh[0] = 1'b1;
        oldest_age   = way_age[COUNTER_WIDTH-1:0];
        for (int i = 1; i < NUM_WAYS; i++) begin
            if (way_age[i*COUNTER_WIDTH +: COUNTER_WIDTH] > oldest_age) begin
                oldest_age   = way_age[i*COUNTER_WIDTH +: COUNTER_WIDTH];
                oldest_oh    = '0;
                oldest_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        if (|invalid_oh) begin
            victim = invalid_oh;
        end else if (|expired_oh) begin
            victim = expired_oh;
        end else begin
            victim = oldest_oh;
        end
    end

    always_comb begin
        victim_age = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (victim[i]) begin
                victim_age = way_age[i*COUNTER_WIDTH +: COUNTER_WIDTH];
            end
        end
    end

endmodule

// File: rtl/lru_replacement_ctrl.sv
// rtl/lru_replacement_ctrl.sv - per-set LRU replacement FSM: hit age update, victim writeback, allocate
// Optional sticky multi-hit flag enabled by LRU_MULTI_HIT_CHECK_EN.
module lru_replacement_ctrl
    import cache_repl_pkg::*;
#(
    parameter int COUNTER_WIDTH = 8,
    parameter int NUM_WAYS      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lru_replacement_ctrl_if.master bus
);

    state_t                            state_q, state_d;
    logic [NUM_WAYS-1:0]               hit_q, hit_d;
    logic [NUM_WAYS-1:0]               valid_q, valid_d;
    logic [NUM_WAYS-1:0]               dirty_q, dirty_d;
    logic [NUM_WAYS-1:0]               expired_q, expired_d;
    logic [NUM_WAYS*COUNTER_WIDTH-1:0] age_q, age_d;
    logic [NUM_WAYS-1:0]               victim_q, victim_d;
    logic [COUNTER_WIDTH-1:0]          victim_age_q, victim_age_d;
    logic                              victim_valid_q, victim_valid_d;

    logic [NUM_WAYS-1:0]               sel_victim;
    logic [COUNTER_WIDTH-1:0]          sel_age;
    logic [NUM_WAYS-1:0]               hit_oh;
    logic [COUNTER_WIDTH-1:0]          hit_age;
    logic                              multi_hit;

    lru_victim_select #(
        .NUM_WAYS      (NUM_WAYS),
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_victim_select (
        .way_valid   (valid_q),
        .way_expired (expired_q),
        .way_age     (age_q),
        .victim      (sel_victim),
        .victim_age  (sel_age)
    );

    assign hit_oh    = NUM_WAYS'(lowest_one(32'(hit_q)));
    assign multi_hit = (hit_q & (hit_q - NUM_WAYS'(1))) != '0;

    always_comb begin
        hit_age = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (hit_oh[i]) begin
                hit_age = age_q[i*COUNTER_WIDTH +: COUNTER_WIDTH];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        hit_d          = hit_q;
        valid_d        = valid_q;
        dirty_d        = dirty_q;
        expired_d      = expired_q;
        age_d          = age_q;
        victim_d       = victim_q;
        victim_age_d   = victim_age_q;
        victim_valid_d = victim_valid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.reqValid) begin
                    hit_d     = bus.wayHit;
                    valid_d   = bus.wayValid;
                    dirty_d   = bus.wayDirty;
                    expired_d = bus.wayExpired;
                    age_d     = bus.wayAge;
                    state_d   = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (|hit_q) begin
                    victim_d = '0;
                    state_d  = S_HIT;
                end else begin
                    victim_d       = sel_victim;
                    victim_age_d   = sel_age;
                    victim_valid_d = |(sel_victim & valid_q);
                    state_d        = (|(sel_victim & valid_q & dirty_q)) ? S_WRITEBACK : S_ALLOC;
                end
            end
            S_HIT: begin
                state_d = S_IDLE;
            end
            S_WRITEBACK: begin
                if (bus.wbAck) begin
                    state_d = S_ALLOC;
                end
            end
            S_ALLOC: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                victim_d = '0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            hit_q          <= '0;
            valid_q        <= '0;
            dirty_q        <= '0;
            expired_q      <= '0;
            age_q          <= '0;
            victim_q       <= '0;
            victim_age_q   <= '0;
            victim_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hit_q          <= hit_d;
            valid_q        <= valid_d;
            dirty_q        <= dirty_d;
            expired_q      <= expired_d;
            age_q          <= age_d;
            victim_q       <= victim_d;
            victim_age_q   <= victim_age_d;
            victim_valid_q <= victim_valid_d;
        end
    end

    // An invalid victim had no age of its own, so every way ages.
    always_comb begin
        bus.accessedWayAge = '0;
        if (state_q == S_HIT) begin
            bus.accessedWayAge = hit_age;
        end else if (state_q == S_ALLOC) begin
            bus.accessedWayAge = victim_valid_q ? victim_age_q : {COUNTER_WIDTH{1'b1}};
        end
    end

    assign bus.reqReady  = (state_q == S_IDLE);
    assign bus.accessed  = (state_q == S_HIT) || (state_q == S_ALLOC);
    assign bus.allocate  = (state_q == S_ALLOC) ? victim_q : '0;
    assign bus.victimWay = victim_q;
    assign bus.wbReq     = (state_q == S_WRITEBACK);
    assign bus.respValid = (state_q == S_HIT) || (state_q == S_RESP);
    assign bus.respHit   = (state_q == S_HIT);

`ifdef LRU_MULTI_HIT_CHECK_EN
    logic multi_hit_err_q, multi_hit_err_d;

    always_comb begin
        multi_hit_err_d = multi_hit_err_q;
        if (state_q == S_LOOKUP && multi_hit) begin
            multi_hit_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multi_hit_err_q <= 1'b0;
        end else begin
            multi_hit_err_q <= multi_hit_err_d;
        end
    end

    assign bus.multiHitErr = multi_hit_err_q || (state_q == S_LOOKUP && multi_hit);
`else
    logic unused_multi_hit;
    assign unused_multi_hit = multi_hit;
`endif

endmodule

// File: tb/tb_lru_replacement_ctrl.sv
// tb/tb_lru_replacement_ctrl.sv - randomized scoreboard bench for lru_replacement_ctrl
module tb_lru_replacement_ctrl;

    localparam int NW = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    lru_replacement_ctrl_if #(.NUM_WAYS(NW), .COUNTER_WIDTH(CW)) bus ();

    lru_replacement_ctrl #(.COUNTER_WIDTH(CW), .NUM_WAYS(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic          hit;
        logic [CW-1:0] age;
        logic [NW-1:0] victim;
        logic          dirty;
        int            n;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ack_after = -1;
    bit   ack_en = 1'b1;
    int   last_wb_cycles = 0;
    logic mh_exp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: lowest hit wins; else first invalid, first expired, then oldest (first on ties).
    function automatic exp_t model(input logic [NW-1:0] h, input logic [NW-1:0] v,
                                   input logic [NW-1:0] d, input logic [NW-1:0] e,
                                   input logic [NW*CW-1:0] a, input int n);
        exp_t r;
        int   vi;
        r.hit = 1'b0; r.age = '0; r.victim = '0; r.dirty = 1'b0; r.n = n;
        vi = -1;
        for (int i = NW - 1; i >= 0; i--) if (h[i]) vi = i;
        if (vi >= 0) begin
            r.hit = 1'b1;
            r.age = a[vi*CW +: CW];
            return r;
        end
        for (int i = NW - 1; i >= 0; i--) if (!v[i]) vi = i;
        if (vi < 0) for (int i = NW - 1; i >= 0; i--) if (e[i]) vi = i;
        if (vi < 0) begin
            vi = 0;
            for (int i = 1; i < NW; i++) if (a[i*CW +: CW] > a[vi*CW +: CW]) vi = i;
        end
        r.victim[vi] = 1'b1;
        r.age   = v[vi] ? a[vi*CW +: CW] : '1;
        r.dirty = v[vi] && d[vi];
        return r;
    endfunction

    // Called on a falling edge; returns on the falling edge after the accept.
    task automatic send(input logic [NW-1:0] h, input logic [NW-1:0] v, input logic [NW-1:0] d,
                        input logic [NW-1:0] e, input logic [NW*CW-1:0] a);
        int w = 0;
        while (!bus.reqReady && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.reqReady) begin
            chk("req_ready_timeout", 0, 1);
            return;
        end
        bus.reqValid   = 1'b1;
        bus.wayHit     = h;
        bus.wayValid   = v;
        bus.wayDirty   = d;
        bus.wayExpired = e;
        bus.wayAge     = a;
        expq.push_back(model(h, v, d, e, a, cyc + 1));
        if ((h & (h - 4'd1)) != 4'd0) mh_exp = 1'b1;
        @(negedge clk);
        bus.reqValid   = 1'b0;
        bus.wayHit     = NW'($urandom);
        bus.wayValid   = NW'($urandom);
        bus.wayDirty   = NW'($urandom);
        bus.wayExpired = NW'($urandom);
        bus.wayAge     = {$urandom, $urandom};
    endtask

    task automatic drain();
        int w = 0;
        while (expq.size() > 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        chk("drain_queue_empty", expq.size(), 0);
    endtask

    initial begin : responder
        int wb_cnt = 0;
        bus.wbAck = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.wbReq && ack_en) begin
                if (ack_after >= 0) bus.wbAck = (wb_cnt == ack_after);
                else                bus.wbAck = ($urandom_range(0, 3) == 0);
                wb_cnt++;
            end else begin
                bus.wbAck = ($urandom_range(0, 7) == 0);
                wb_cnt = 0;
            end
        end
    end

    initial begin : monitor
        exp_t          e;
        logic          acc_seen = 1'b0;
        logic          wb_seen = 1'b0;
        logic [CW-1:0] acc_age_s = '0;
        logic [NW-1:0] alloc_s = '0;
        logic [NW-1:0] vic_s = '0;
        int            ack_cyc = 0;
        int            wb_cycles = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                acc_seen = 1'b0; wb_seen = 1'b0; wb_cycles = 0;
            end else begin
                if (bus.wbReq) begin
                    wb_seen = 1'b1;
                    wb_cycles++;
                    if (bus.wbAck) ack_cyc = cyc;
                end
                if (bus.accessed) begin
                    acc_seen  = 1'b1;
                    acc_age_s = bus.accessedWayAge;
                    alloc_s   = bus.allocate;
                    vic_s     = bus.victimWay;
                end
                if (bus.respValid) begin
                    if (expq.size() == 0) begin
                        chk("resp_unexpected", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        chk("resp_hit", bus.respHit, e.hit);
                        chk("accessed_seen", acc_seen, 1);
                        chk("accessed_age", acc_age_s, e.age);
                        chk("allocate", alloc_s, e.hit ? '0 : e.victim);
                        chk("victim_way", vic_s, e.victim);
                        chk("wb_seen", wb_seen, e.dirty);
                        chk("latency", cyc, e.dirty ? ack_cyc + 2 : e.n + (e.hit ? 1 : 2));
`ifdef LRU_MULTI_HIT_CHECK_EN
                        chk("multi_hit_err", bus.multiHitErr, mh_exp);
`endif
                    end
                    acc_seen = 1'b0;
                    wb_seen = 1'b0;
                    last_wb_cycles = wb_cycles;
                    wb_cycles = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [NW-1:0]    h, v, d, e;
        logic [NW*CW-1:0] a;
        int               w;
        bus.reqValid = 1'b0;
        bus.wayHit = '0; bus.wayValid = '0; bus.wayDirty = '0; bus.wayExpired = '0; bus.wayAge = '0;
        #2;
        chk("rst_req_ready", bus.reqReady, 1);
        chk("rst_accessed", bus.accessed, 0);
        chk("rst_age", bus.accessedWayAge, 0);
        chk("rst_allocate", bus.allocate, 0);
        chk("rst_victim", bus.victimWay, 0);
        chk("rst_wb_req", bus.wbReq, 0);
        chk("rst_resp_valid", bus.respValid, 0);
        chk("rst_resp_hit", bus.respHit, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(4'b0100, 4'b1111, 4'b0000, 4'b0000, {8'd0, 8'd7, 8'd1, 8'd3});
        send(4'b0000, 4'b1011, 4'b1111, 4'b0000, {8'd40, 8'd30, 8'd20, 8'd10});
        drain();
        ack_after = 3;
        send(4'b0000, 4'b1111, 4'b0010, 4'b0000, {8'd2, 8'd9, 8'd9, 8'd5});
        drain();
        chk("wb_hold_cycles", last_wb_cycles, 4);
        ack_after = -1;
        send(4'b0000, 4'b1111, 4'b0000, 4'b1000, {8'd1, 8'd0, 8'd0, 8'd200});
        drain();

        ack_en = 1'b0;
        send(4'b0000, 4'b1111, 4'b0001, 4'b0000, {8'd1, 8'd2, 8'd3, 8'd50});
        w = 0;
        while (!bus.wbReq && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("wb_reached", bus.wbReq, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_wb_req", bus.wbReq, 0);
        chk("rst_mid_ready", bus.reqReady, 1);
        chk("rst_mid_resp", bus.respValid, 0);
        expq.delete();
        mh_exp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ack_en = 1'b1;
        repeat (4) @(negedge clk);
        send(4'b0001, 4'b1111, 4'b0000, 4'b0000, {8'd4, 8'd3, 8'd2, 8'd1});
        drain();

        for (int t = 0; t < 300; t++) begin
            h = ($urandom_range(0, 2) == 0) ? NW'($urandom) : '0;
            v = ($urandom_range(0, 1) == 0) ? '1 : NW'($urandom);
            d = NW'($urandom);
            e = ($urandom_range(0, 3) == 0) ? NW'($urandom) : '0;
            for (int i = 0; i < NW; i++)
                a[i*CW +: CW] = ($urandom_range(0, 1) == 0) ? CW'($urandom_range(0, 7)) : CW'($urandom);
            send(h, v, d, e, a);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
